// File: rtl/mem_stage.sv
// mem_stage -- memory stage of the in-order pipeline.
//
// Purpose:
//   Takes one instruction per cycle from EX. Loads and stores run a simple
//   two-state (IDLE/BUSY) handshake on the data-memory bus and hold EX via
//   `stall` until the memory answers. Every other instruction passes
//   through in one registered cycle. Jumps and taken branches raise a
//   fetch redirect. A misaligned load or store is rejected without touching
//   the bus and is flagged on `misaligned`.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   ex_valid            EX presents a valid instruction this cycle
//   opcode_to_mem, funct3_to_mem, pc_to_mem, jump_or_branch,
//   b (store data), c (ALU result / address), reg_wr_addr   from EX
//   stall               EX must hold its outputs while high
//   mem_req, mem_we, mem_addr, mem_wdata, mem_be            request to memory
//   mem_ready, mem_rdata                                    response from memory
//   wb_valid, wb_reg_we, wb_rd, wb_data                     to WB
//   redirect, redirect_pc                                   to fetch
//   misaligned          one-cycle flag for a rejected misaligned access
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [6:0]  opcode_to_mem,
  input  logic [2:0]  funct3_to_mem,
  input  logic [31:0] pc_to_mem,
  input  logic        jump_or_branch,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [4:0]  reg_wr_addr,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_reg_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        misaligned
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_reg_we_q, wb_reg_we_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        redirect_q, redirect_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        misaligned_q, misaligned_d;

  logic        is_load, is_store, is_mem, is_jal, is_jalr, is_branch;
  logic        writes_rd, aligned, accept;
  logic [31:0] store_wdata;
  logic [3:0]  store_be;
  logic [31:0] shifted;
  logic [31:0] load_data;

  // Decode the incoming EX instruction. The low two funct3 bits give the
  // access size for both loads and stores (00 byte, 01 half, 10 word), so
  // one alignment check and one lane-steering table serve both.
  always_comb begin
    is_load   = (opcode_to_mem == OPC_LOAD);
    is_store  = (opcode_to_mem == OPC_STORE);
    is_mem    = is_load || is_store;
    is_jal    = (opcode_to_mem == OPC_JAL);
    is_jalr   = (opcode_to_mem == OPC_JALR);
    is_branch = (opcode_to_mem == OPC_BRANCH);
    writes_rd = (opcode_to_mem == OPC_LUI) || (opcode_to_mem == OPC_AUIPC) ||
                (opcode_to_mem == OPC_OP)  || (opcode_to_mem == OPC_OPIMM) ||
                is_jal || is_jalr;
    case (funct3_to_mem[1:0])
      2'b00: begin
        aligned     = 1'b1;
        store_wdata = {4{b[7:0]}};
        store_be    = 4'b0001 << c[1:0];
      end
      2'b01: begin
        aligned     = ~c[0];
        store_wdata = {2{b[15:0]}};
        store_be    = 4'b0011 << c[1:0];
      end
      default: begin
        aligned     = (c[1:0] == 2'b00);
        store_wdata = b;
        store_be    = 4'b1111;
      end
    endcase
    accept = (state_q == IDLE) && ex_valid && is_mem && aligned;
  end

  // Move the addressed byte/half down to bit 0 of the returned word, then
  // sign- or zero-extend it according to the latched funct3.
  always_comb begin
    shifted = mem_rdata >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'h000000, shifted[7:0]};
      3'b101:  load_data = {16'h0000, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // Next-state logic. The WB-facing pulses default to zero every cycle so
  // each instruction produces exactly one wb_valid; the bus request fields
  // are written only when a memory op is accepted, which keeps them stable
  // for the whole BUSY period however long memory takes.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    funct3_d      = funct3_q;
    rd_d          = rd_q;
    mem_we_d      = mem_we_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;
    wb_valid_d    = 1'b0;
    wb_reg_we_d   = 1'b0;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    misaligned_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (accept) begin
            state_d     = BUSY;
            addr_d      = c;
            funct3_d    = funct3_to_mem;
            rd_d        = reg_wr_addr;
            mem_we_d    = is_store;
            mem_wdata_d = is_store ? store_wdata : 32'h0;
            mem_be_d    = is_store ? store_be : 4'b1111;
          end else if (is_mem) begin
            wb_valid_d   = 1'b1;
            misaligned_d = 1'b1;
            wb_rd_d      = reg_wr_addr;
            wb_data_d    = c;
          end else begin
            wb_valid_d  = 1'b1;
            wb_rd_d     = reg_wr_addr;
            wb_data_d   = (is_jal || is_jalr) ? (pc_to_mem + 32'd4) : c;
            wb_reg_we_d = writes_rd && (reg_wr_addr != 5'd0);
            redirect_d  = is_jal || is_jalr || (is_branch && jump_or_branch);
            if (redirect_d) begin
              redirect_pc_d = is_jalr ? {c[31:1], 1'b0} : c;
            end
          end
        end
      end
      BUSY: begin
        if (mem_ready) begin
          state_d     = IDLE;
          wb_valid_d  = 1'b1;
          wb_rd_d     = rd_q;
          wb_reg_we_d = !mem_we_q && (rd_q != 5'd0);
          wb_data_d   = mem_we_q ? wb_data_q : load_data;
          mem_we_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All state, including the FSM, updates here; reset clears every
  // register, which also abandons an in-flight access with no writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= 32'h0;
      funct3_q      <= 3'b000;
      rd_q          <= 5'd0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= 32'h0;
      mem_be_q      <= 4'b0000;
      wb_valid_q    <= 1'b0;
      wb_reg_we_q   <= 1'b0;
      wb_rd_q       <= 5'd0;
      wb_data_q     <= 32'h0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'h0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      funct3_q      <= funct3_d;
      rd_q          <= rd_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
      wb_valid_q    <= wb_valid_d;
      wb_reg_we_q   <= wb_reg_we_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      misaligned_q  <= misaligned_d;
    end
  end

  // stall must rise in the same cycle a memory op is accepted so EX holds
  // it; it is gated by rst so it reads low while reset is applied.
  always_comb begin
    stall       = !rst && ((state_q == BUSY) || accept);
    mem_req     = (state_q == BUSY);
    mem_we      = mem_we_q;
    mem_addr    = {addr_q[31:2], 2'b00};
    mem_wdata   = mem_wdata_q;
    mem_be      = mem_be_q;
    wb_valid    = wb_valid_q;
    wb_reg_we   = wb_reg_we_q;
    wb_rd       = wb_rd_q;
    wb_data     = wb_data_q;
    redirect    = redirect_q;
    redirect_pc = redirect_pc_q;
    misaligned  = misaligned_q;
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- scoreboard bench for mem_stage.
//
// Stimulus tasks drive directed instructions and push the hand-computed
// writeback they should produce into a queue; an independent monitor pops
// that queue whenever wb_valid is seen. Bus-side behaviour (address, byte
// enables, write data, stall, handshake timing) is checked in the tasks.
module tb_mem_stage;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [6:0]  opcode_to_mem;
  logic [2:0]  funct3_to_mem;
  logic [31:0] pc_to_mem;
  logic        jump_or_branch;
  logic [31:0] b;
  logic [31:0] c;
  logic [4:0]  reg_wr_addr;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic        wb_reg_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misaligned;

  typedef struct {
    string       name;
    logic        reg_we;
    logic        chk_rd_data;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        misaligned;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests  = 0;
  int   failed = 0;
  logic mon_en = 1'b0;

  mem_stage dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .opcode_to_mem  (opcode_to_mem),
    .funct3_to_mem  (funct3_to_mem),
    .pc_to_mem      (pc_to_mem),
    .jump_or_branch (jump_or_branch),
    .b              (b),
    .c              (c),
    .reg_wr_addr    (reg_wr_addr),
    .stall          (stall),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_be         (mem_be),
    .mem_ready      (mem_ready),
    .mem_rdata      (mem_rdata),
    .wb_valid       (wb_valid),
    .wb_reg_we      (wb_reg_we),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .misaligned     (misaligned)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drives one instruction for a single cycle, checking stall in that cycle
  // and, just after the edge, whether a writeback or a bus request started.
  task automatic applyStimulus(input string name, input logic [6:0] op,
                               input logic [2:0] f3, input logic [31:0] pc,
                               input logic jb, input logic [31:0] bval,
                               input logic [31:0] cval, input logic [4:0] rd,
                               input logic exp_stall);
    ex_valid       = 1'b1;
    opcode_to_mem  = op;
    funct3_to_mem  = f3;
    pc_to_mem      = pc;
    jump_or_branch = jb;
    b              = bval;
    c              = cval;
    reg_wr_addr    = rd;
    @(negedge clk);
    checkOutput({name, "_stall"}, {31'b0, stall}, {31'b0, exp_stall});
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    checkOutput({name, "_req"}, {31'b0, mem_req}, {31'b0, exp_stall});
    checkOutput({name, "_wbv"}, {31'b0, wb_valid}, {31'b0, ~exp_stall});
  endtask

  task automatic pushExp(input string name, input logic we, input logic chk,
                         input logic [4:0] rd, input logic [31:0] data,
                         input logic rdr, input logic [31:0] rpc,
                         input logic mis);
    exp_t e;
    e.name = name; e.reg_we = we; e.chk_rd_data = chk; e.rd = rd;
    e.data = data; e.redirect = rdr; e.redirect_pc = rpc; e.misaligned = mis;
    exp_q.push_back(e);
  endtask

  // Aligned load/store: checks the bus request is held steady through the
  // wait cycles, then answers with mem_ready and checks wb_valid timing.
  task automatic memOp(input string name, input logic [6:0] op,
                       input logic [2:0] f3, input logic [31:0] bval,
                       input logic [31:0] cval, input logic [4:0] rd,
                       input int waits, input logic [31:0] rdata,
                       input logic [31:0] exp_addr, input logic [3:0] exp_be,
                       input logic [31:0] exp_wdata, input logic exp_we);
    applyStimulus(name, op, f3, 32'h0, 1'b0, bval, cval, rd, 1'b1);
    for (int i = 0; i <= waits; i++) begin
      if (i == waits) begin
        mem_ready = 1'b1;
        mem_rdata = rdata;
      end
      @(negedge clk);
      checkOutput({name, "_busy_req"}, {31'b0, mem_req}, 32'd1);
      checkOutput({name, "_busy_stall"}, {31'b0, stall}, 32'd1);
      checkOutput({name, "_addr"}, mem_addr, exp_addr);
      checkOutput({name, "_be"}, {28'b0, mem_be}, {28'b0, exp_be});
      checkOutput({name, "_we"}, {31'b0, mem_we}, {31'b0, exp_we});
      if (exp_we) checkOutput({name, "_wdata"}, mem_wdata, exp_wdata);
      checkOutput({name, "_early_wbv"}, {31'b0, wb_valid}, 32'd0);
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    checkOutput({name, "_wbv_timing"}, {31'b0, wb_valid}, 32'd1);
    checkOutput({name, "_idle_req"}, {31'b0, mem_req}, 32'd0);
    checkOutput({name, "_idle_stall"}, {31'b0, stall}, 32'd0);
  endtask

  // Scoreboard monitor: compares each writeback against the oldest
  // expectation, and flags redirect/misaligned outside a writeback.
  always @(negedge clk) begin
    if (mon_en) begin
      if (wb_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("[TB] FAIL unexpected_wb: got wb_valid=1 expected no writeback");
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput({mon_e.name, "_wb_we"}, {31'b0, wb_reg_we}, {31'b0, mon_e.reg_we});
          checkOutput({mon_e.name, "_redirect"}, {31'b0, redirect}, {31'b0, mon_e.redirect});
          checkOutput({mon_e.name, "_misaligned"}, {31'b0, misaligned}, {31'b0, mon_e.misaligned});
          if (mon_e.redirect)
            checkOutput({mon_e.name, "_redirect_pc"}, redirect_pc, mon_e.redirect_pc);
          if (mon_e.chk_rd_data) begin
            checkOutput({mon_e.name, "_wb_rd"}, {27'b0, wb_rd}, {27'b0, mon_e.rd});
            checkOutput({mon_e.name, "_wb_data"}, wb_data, mon_e.data);
          end
        end
      end else begin
        checkOutput("no_stray_pulse", {30'b0, redirect, misaligned}, 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b1; ex_valid = 1'b0; opcode_to_mem = 7'h0; funct3_to_mem = 3'h0;
    pc_to_mem = 32'h0; jump_or_branch = 1'b0; b = 32'h0; c = 32'h0;
    reg_wr_addr = 5'd0; mem_ready = 1'b0; mem_rdata = 32'h0;

    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ctrl", {25'b0, stall, mem_req, mem_we, wb_valid, wb_reg_we, redirect, misaligned}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    checkOutput("rst_mem_be", {28'b0, mem_be}, 32'd0);
    checkOutput("rst_wb_data", wb_data, 32'h0);
    checkOutput("rst_redirect_pc", redirect_pc, 32'h0);
    checkOutput("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // LB: byte 3 of 0x80FF0000 is 0x80, sign-extended.
    pushExp("lb", 1'b1, 1'b1, 5'd5, 32'hFFFF_FF80, 1'b0, 32'h0, 1'b0);
    memOp("lb", OPC_LOAD, 3'b000, 32'h0, 32'h0000_0103, 5'd5, 2, 32'h80FF_0000,
          32'h0000_0100, 4'b1111, 32'h0, 1'b0);
    // LBU: byte 1 of 0x00009A00 is 0x9A, zero-extended.
    pushExp("lbu", 1'b1, 1'b1, 5'd6, 32'h0000_009A, 1'b0, 32'h0, 1'b0);
    memOp("lbu", OPC_LOAD, 3'b100, 32'h0, 32'h0000_0101, 5'd6, 0, 32'h0000_9A00,
          32'h0000_0100, 4'b1111, 32'h0, 1'b0);
    // LH / LHU: upper half 0x8001 sign- and zero-extended.
    pushExp("lh", 1'b1, 1'b1, 5'd7, 32'hFFFF_8001, 1'b0, 32'h0, 1'b0);
    memOp("lh", OPC_LOAD, 3'b001, 32'h0, 32'h0000_0102, 5'd7, 1, 32'h8001_0000,
          32'h0000_0100, 4'b1111, 32'h0, 1'b0);
    pushExp("lhu", 1'b1, 1'b1, 5'd8, 32'h0000_8001, 1'b0, 32'h0, 1'b0);
    memOp("lhu", OPC_LOAD, 3'b101, 32'h0, 32'h0000_0102, 5'd8, 0, 32'h8001_0000,
          32'h0000_0100, 4'b1111, 32'h0, 1'b0);
    // LW into x0: data still returned, no register write.
    pushExp("lw_x0", 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
    memOp("lw_x0", OPC_LOAD, 3'b010, 32'h0, 32'h0000_0104, 5'd0, 0, 32'hDEAD_BEEF,
          32'h0000_0104, 4'b1111, 32'h0, 1'b0);
    // Stores: lane steering and replication.
    pushExp("sh", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    memOp("sh", OPC_STORE, 3'b001, 32'h0000_ABCD, 32'h0000_0202, 5'd0, 1, 32'h0,
          32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 1'b1);
    pushExp("sb", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    memOp("sb", OPC_STORE, 3'b000, 32'h1234_5678, 32'h0000_0003, 5'd0, 0, 32'h0,
          32'h0000_0000, 4'b1000, 32'h7878_7878, 1'b1);
    pushExp("sw", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    memOp("sw", OPC_STORE, 3'b010, 32'hCAFE_F00D, 32'h0000_0010, 5'd0, 0, 32'h0,
          32'h0000_0010, 4'b1111, 32'hCAFE_F00D, 1'b1);

    // Misaligned accesses: no request, flagged writeback.
    pushExp("lw_mis", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1);
    applyStimulus("lw_mis", OPC_LOAD, 3'b010, 32'h0, 1'b0, 32'h0, 32'h0000_0105, 5'd9, 1'b0);
    pushExp("sh_mis", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1);
    applyStimulus("sh_mis", OPC_STORE, 3'b001, 32'h0, 1'b0, 32'h55, 32'h0000_0201, 5'd0, 1'b0);

    // Non-memory ops issued back to back.
    pushExp("jalr", 1'b1, 1'b1, 5'd1, 32'h0000_0044, 1'b1, 32'h0000_1000, 1'b0);
    applyStimulus("jalr", OPC_JALR, 3'b000, 32'h40, 1'b0, 32'h0, 32'h0000_1001, 5'd1, 1'b0);
    pushExp("jal_x0", 1'b0, 1'b1, 5'd0, 32'h0000_0104, 1'b1, 32'h0000_0200, 1'b0);
    applyStimulus("jal_x0", OPC_JAL, 3'b000, 32'h100, 1'b0, 32'h0, 32'h0000_0200, 5'd0, 1'b0);
    pushExp("br_nt", 1'b0, 1'b1, 5'd7, 32'h0000_0300, 1'b0, 32'h0, 1'b0);
    applyStimulus("br_nt", OPC_BRANCH, 3'b000, 32'h80, 1'b0, 32'h0, 32'h0000_0300, 5'd7, 1'b0);
    pushExp("br_t", 1'b0, 1'b1, 5'd2, 32'h0000_0400, 1'b1, 32'h0000_0400, 1'b0);
    applyStimulus("br_t", OPC_BRANCH, 3'b001, 32'h84, 1'b1, 32'h0, 32'h0000_0400, 5'd2, 1'b0);
    pushExp("add_x0", 1'b0, 1'b1, 5'd0, 32'h0000_0055, 1'b0, 32'h0, 1'b0);
    applyStimulus("add_x0", OPC_OP, 3'b000, 32'h88, 1'b0, 32'h0, 32'h0000_0055, 5'd0, 1'b0);
    pushExp("addi", 1'b1, 1'b1, 5'd3, 32'h0000_1234, 1'b0, 32'h0, 1'b0);
    applyStimulus("addi", OPC_OPIMM, 3'b000, 32'h8C, 1'b0, 32'h0, 32'h0000_1234, 5'd3, 1'b0);
    pushExp("lui", 1'b1, 1'b1, 5'd4, 32'hABCD_E000, 1'b0, 32'h0, 1'b0);
    applyStimulus("lui", OPC_LUI, 3'b000, 32'h90, 1'b0, 32'h0, 32'hABCD_E000, 5'd4, 1'b0);

    // Reset while BUSY abandons the access with no writeback.
    applyStimulus("rst_busy", OPC_LOAD, 3'b010, 32'h0, 1'b0, 32'h0, 32'h0000_0200, 5'd10, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_busy_req", {31'b0, mem_req}, 32'd0);
    checkOutput("rst_busy_stall", {31'b0, stall}, 32'd0);
    checkOutput("rst_busy_wbv", {31'b0, wb_valid}, 32'd0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset sampled on rising edge of clk.
REQ-003 SHALL have port ex_valid, input, 1, EX outputs below carry a valid instruction this cycle.
REQ-004 SHALL have ports opcode_to_mem (7), funct3_to_mem (3), pc_to_mem (32), jump_or_branch (1), b (32, store data), c (32, ALU result/address), reg_wr_addr (5), all inputs from EX stage.
REQ-005 SHALL have port stall, output, 1, EX stage holds all its outputs while high.
REQ-006 SHALL have ports mem_req (out 1), mem_we (out 1), mem_addr (out 32, word-aligned), mem_wdata (out 32), mem_be (out 4), mem_ready (in 1), mem_rdata (in 32), the data-memory bus.
REQ-007 SHALL have ports wb_valid (out 1), wb_reg_we (out 1), wb_rd (out 5), wb_data (out 32), to WB stage.
REQ-008 SHALL have ports redirect (out 1), redirect_pc (out 32), to fetch.
REQ-009 SHALL have port misaligned (out 1), one-cycle pulse flagging a rejected misaligned access.

Function
REQ-010 SHALL implement FSM states IDLE and BUSY; reset state IDLE.
REQ-011 In IDLE with ex_valid=1 and opcode LOAD (0000011) or STORE (0100011) and aligned address: SHALL latch c, b, funct3, rd, opcode; next cycle enter BUSY.
REQ-012 Alignment: word access requires c[1:0]=00, half requires c[0]=0, byte always aligned.
REQ-013 stall SHALL be 1 in IDLE when accepting an aligned memory op and throughout BUSY; 0 otherwise.
REQ-014 In BUSY: mem_req=1; mem_addr, mem_we, mem_wdata, mem_be SHALL stay constant until mem_ready=1 is sampled; mem_req=0 in IDLE.
REQ-015 mem_addr = {addr[31:2],2'b00}; mem_we=1 for STORE only.
REQ-016 Store: SB mem_wdata={4{b[7:0]}}, mem_be=0001<<addr[1:0]; SH mem_wdata={2{b[15:0]}}, mem_be=0011<<addr[1:0]; SW mem_wdata=b, mem_be=1111; loads mem_be=1111.
REQ-017 On BUSY cycle with mem_ready=1: SHALL return to IDLE; next cycle wb_valid=1.
REQ-018 Load extract from mem_rdata shifted right by 8*addr[1:0]: LB sign-extend byte, LH sign-extend half, LW full word, LBU/LHU zero-extend; wb_reg_we=1 unless rd=0.
REQ-019 Store completion: wb_valid=1, wb_reg_we=0.
REQ-020 Non-memory ex_valid op in IDLE: one-cycle registered pass-through; wb_valid=1; wb_rd=reg_wr_addr.
REQ-021 wb_data SHALL be pc_to_mem+4 for JAL (1101111)/JALR (1100111), else c; wb_reg_we=1 for LUI, AUIPC, OP, OP-IMM, JAL, JALR with rd!=0; 0 for BRANCH and STORE.
REQ-022 redirect SHALL be registered (same cycle as wb_valid): 1 for JAL, JALR, or BRANCH (1100011) with jump_or_branch=1; redirect_pc=c, with bit0 cleared for JALR.
REQ-023 Misaligned memory op: no bus request, no BUSY; next cycle misaligned=1, wb_valid=1, wb_reg_we=0.
REQ-024 wb_valid, redirect, misaligned SHALL be single-cycle pulses per instruction; ex_valid ignored in BUSY.
REQ-025 Latency: non-memory 1 cycle; memory 2 cycles + wait cycles before mem_ready.

Reset
REQ-026 On rst=1: state IDLE; stall, mem_req, mem_we, wb_valid, wb_reg_we, redirect, misaligned = 0; mem_addr, mem_wdata, wb_data, redirect_pc = 0; mem_be=0000; wb_rd=0.
REQ-027 rst asserted in BUSY SHALL abandon the access (mem_req=0 next cycle), produce no wb_valid.

Verification
REQ-028 LB: c=0x00000103, mem_rdata=0x80FF_0000 after 2 wait cycles -> mem_addr=0x100, wb_data=0xFFFFFF80, wb_valid 1 cycle after mem_ready.
REQ-029 SH: c=0x202, b=0x0000ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, stall high until mem_ready, wb_reg_we=0.
REQ-030 LW c=0x105 -> no mem_req, misaligned=1, wb_reg_we=0.
REQ-031 JALR pc=0x40, c=0x1001, rd=1 -> next cycle redirect=1, redirect_pc=0x1000, wb_data=0x44.
REQ-032 BRANCH jump_or_branch=0 -> redirect=0, wb_reg_we=0; ADD rd=0 -> wb_reg_we=0.
REQ-033 rst asserted during BUSY with mem_ready=0 -> next cycle mem_req=0, stall=0, no wb_valid.
